// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch sequencer state encoding, default addresses and pc-to-index helper
package fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_3000;

    // Word offset from the memory base; callers slice it down to their index width.
    function automatic logic [29:0] pc_to_idx(input logic [31:0] pc, input logic [31:0] base);
        return 30'((pc - base) >> 2);
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - combinational fetch address decode: misaligned, out_of_range, word index
module fetch_addr_check
    import fetch_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int          IMEM_WORDS = 4096,
    parameter int          IDX_W      = 12
) (
    input  logic [31:0]      pc,
    output logic             misaligned,
    output logic             out_of_range,
    output logic [IDX_W-1:0] idx
);

    logic [29:0] word_off;

    assign word_off     = pc_to_idx(pc, IMEM_BASE);
    assign misaligned   = (pc[1:0] != 2'b00);
    // Below-base addresses wrap to huge offsets, so both bounds are tested explicitly.
    assign out_of_range = (pc < IMEM_BASE) || (word_off >= 30'(IMEM_WORDS));
    assign idx          = word_off[IDX_W-1:0];

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - instruction fetch sequencer; define FETCH_PERF_CNT_EN for fetch_count
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int          IMEM_WORDS = 4096,
    parameter int          IDX_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [IDX_W-1:0] imem_idx,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic             fault,
    output logic [31:0]      fetch_count
);

    logic [1:0]       state;
    logic [31:0]      pend_pc;
    logic             squash;
    logic [31:0]      next_pc;
    logic             start_req;
    logic             take_instr;
    logic             chk_misaligned;
    logic             chk_out_of_range;
    logic [IDX_W-1:0] chk_idx;

    fetch_addr_check #(
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_WORDS (IMEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_addr_check (
        .pc           (next_pc),
        .misaligned   (chk_misaligned),
        .out_of_range (chk_out_of_range),
        .idx          (chk_idx)
    );

    // start_req marks every path into REQ; next_pc is the address that request would use.
    always_comb begin
        start_req  = 1'b0;
        take_instr = 1'b0;
        next_pc    = pc;
        case (state)
            ST_IDLE: begin
                start_req = 1'b1;
                if (redirect_valid) next_pc = redirect_pc;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        start_req = 1'b1;
                        next_pc   = redirect_pc;
                    end else if (squash) begin
                        start_req = 1'b1;
                        next_pc   = pend_pc;
                    end else begin
                        take_instr = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    start_req = 1'b1;
                    next_pc   = redirect_pc;
                end else if (instr_ready) begin
                    start_req = 1'b1;
                    next_pc   = pc + 32'd4;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            pend_pc  <= '0;
            squash   <= 1'b0;
            instr    <= '0;
            fault    <= 1'b0;
            imem_idx <= '0;
        end else if (start_req) begin
            pc     <= next_pc;
            squash <= 1'b0;
            if (chk_misaligned || chk_out_of_range) begin
                fault    <= 1'b1;
                state    <= ST_FAULT;
                imem_idx <= '0;
            end else begin
                state    <= ST_REQ;
                imem_idx <= chk_idx;
            end
        end else if (take_instr) begin
            instr    <= imem_rdata;
            state    <= ST_HOLD;
            imem_idx <= '0;
        end else if (state == ST_REQ && redirect_valid) begin
            // The read in flight cannot be cancelled; remember where to go once it returns.
            pend_pc <= redirect_pc;
            squash  <= 1'b1;
        end
    end

    assign imem_req    = (state == ST_REQ);
    assign instr_valid = (state == ST_HOLD);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (instr_valid && instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - randomized and directed bench for fetch_seq_ctrl against a transaction-level model
module tb_fetch_seq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [11:0] imem_idx;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_idx       (imem_idx),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: the pc decode must see next, instructions accepted, outstanding read.
    logic [31:0] m_target;
    int unsigned m_count;
    logic        m_out;
    logic [11:0] m_req_idx;
    logic        m_fault_ok;
    int          lat;
    int          wait_cnt;

    logic        s_req, s_valid, s_fault;
    logic [11:0] s_idx;
    logic [31:0] s_pc, s_instr;

    logic [31:0] vpc_q[$];
    int          vcyc_q[$];
    logic [11:0] ridx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mword(input logic [11:0] i);
        return ({20'h0, i} * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [11:0] t_idx(input logic [31:0] a);
        return 12'((a - BASE) >> 2);
    endfunction

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || ((a - BASE) >= 32'h4000);
    endfunction

    task automatic model_check();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_count);
`else
        chk("fetch_count", fetch_count, 32'h0);
`endif
        chk("req_valid_excl", {31'h0, imem_req & instr_valid}, 32'h0);
        if (instr_valid) begin
            chk("pc", pc, m_target);
            chk("instr", instr, mword(t_idx(m_target)));
        end
        if (imem_req && !m_out) begin
            chk("req_addr_ok", {31'h0, bad(m_target)}, 32'h0);
            chk("imem_idx_new", {20'h0, imem_idx}, {20'h0, t_idx(m_target)});
            m_req_idx = t_idx(m_target);
        end else if (imem_req) begin
            chk("imem_idx_stable", {20'h0, imem_idx}, {20'h0, m_req_idx});
        end
        if (fault) begin
            chk("fault_cause", {31'h0, m_fault_ok}, 32'h1);
            chk("fault_quiet", {31'h0, imem_req | instr_valid}, 32'h0);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        cyc++;
        s_req   = imem_req;
        s_valid = instr_valid;
        s_fault = fault;
        s_idx   = imem_idx;
        s_pc    = pc;
        s_instr = instr;
        model_check();
        if (s_req && !m_out) ridx_q.push_back(s_idx);
        if (s_valid) begin
            vpc_q.push_back(s_pc);
            vcyc_q.push_back(cyc);
        end
        imem_ack       = s_req && (wait_cnt >= lat);
        imem_rdata     = imem_ack ? mword(s_idx) : 32'hDEAD_BEEF;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        wait_cnt       = (s_req && !imem_ack) ? wait_cnt + 1 : 0;
        if (s_valid && rdy) m_count++;
        if (rv) begin
            m_target = rpc;
            if (bad(rpc)) m_fault_ok = 1'b1;
        end else if (s_valid && rdy) begin
            m_target = m_target + 32'd4;
            if (bad(m_target)) m_fault_ok = 1'b1;
        end
        m_out = s_req && !imem_ack;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        m_target       = BASE;
        m_count        = 0;
        m_out          = 1'b0;
        m_fault_ok     = 1'b0;
        wait_cnt       = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_valid(input logic rdy, input string name);
        int n = 0;
        do begin
            step(1'b0, 32'h0, rdy);
            n++;
        end while (!s_valid && n < 50);
        chk({name, "_reached_valid"}, {31'h0, s_valid}, 32'h1);
    endtask

    task automatic clear_logs();
        vpc_q.delete();
        vcyc_q.delete();
        ridx_q.delete();
    endtask

    task automatic expect_fault(input string name);
        int reqs = 0;
        repeat (4) begin
            step(1'b0, 32'h0, 1'b1);
            if (s_req || s_valid) reqs++;
        end
        chk({name, "_fault"}, {31'h0, s_fault}, 32'h1);
        chk({name, "_no_req"}, reqs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] p, w;
        int nreq, moved, reqs, idle, vcnt;

        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0; lat = 0;
        #1;
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_imem_idx", {20'h0, imem_idx}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'h0);
        do_reset();

        // Zero-wait memory, decode always ready.
        lat = 0; clear_logs();
        repeat (6) step(1'b0, 32'h0, 1'b1);
        chk("t1_nvalid", vpc_q.size(), 3);
        chk("t1_first_idx", {20'h0, ridx_q[0]}, 32'h0);
        chk("t1_pc0", vpc_q[0], 32'h3000);
        chk("t1_pc1", vpc_q[1], 32'h3004);
        chk("t1_spacing", vcyc_q[1] - vcyc_q[0], 2);

        // Ack delayed by three cycles.
        lat = 3; clear_logs(); nreq = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (s_req) nreq++;
            if (s_valid) break;
        end
        chk("t2_req_cycles", nreq, 4);
        chk("t2_nvalid", vpc_q.size(), 1);
        chk("t2_pc", vpc_q[0], 32'h300C);

        // Redirect while a read is pending.
        clear_logs();
        step(1'b1, 32'h3040, 1'b1);
        run_until_valid(1'b1, "t3");
        chk("t3_nvalid", vpc_q.size(), 1);
        chk("t3_pc", vpc_q[0], 32'h3040);
        chk("t3_nreq", ridx_q.size(), 2);
        chk("t3_new_idx", {20'h0, ridx_q[ridx_q.size()-1]}, 32'h10);

        // Decode stalls for five cycles.
        lat = 0;
        run_until_valid(1'b0, "t4");
        p = s_pc; w = s_instr; moved = 0; reqs = 0;
        chk("t4_pc", p, 32'h3044);
        repeat (4) begin
            step(1'b0, 32'h0, 1'b0);
            if (!s_valid || s_pc != p || s_instr != w) moved++;
            if (s_req) reqs++;
        end
        chk("t4_held", moved, 0);
        chk("t4_no_req", reqs, 0);
        step(1'b0, 32'h0, 1'b1);
        run_until_valid(1'b0, "t4b");
        chk("t4_next_pc", s_pc, p + 32'd4);
        step(1'b0, 32'h0, 1'b1);

        // Last word of memory, then pc+4 leaves the range.
        step(1'b1, 32'h6FFC, 1'b1);
        run_until_valid(1'b1, "top");
        chk("top_pc", s_pc, 32'h6FFC);
        expect_fault("top");

        // Misaligned redirect.
        do_reset();
        chk("t5_rst_pc", pc, 32'h3000);
        chk("t5_rst_fault", {31'h0, fault}, 32'h0);
        run_until_valid(1'b0, "t5a");
        step(1'b1, 32'h3002, 1'b0);
        expect_fault("t5a");

        // Out-of-range redirect while decode accepts.
        do_reset();
        chk("t5b_rst_fault", {31'h0, fault}, 32'h0);
        run_until_valid(1'b0, "t5b");
        step(1'b1, 32'h7000, 1'b1);
        expect_fault("t5b");

        // Reset asserted in the middle of a pending read.
        do_reset();
        lat = 3;
        step(1'b0, 32'h0, 1'b1);
        chk("t6_req_before", {31'h0, s_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_req_async", {31'h0, imem_req}, 32'h0);
        chk("t6_idx_async", {20'h0, imem_idx}, 32'h0);
        chk("t6_valid_async", {31'h0, instr_valid}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        lat = 0; clear_logs();
        run_until_valid(1'b1, "t6");
        chk("t6_restart_pc", vpc_q[0], 32'h3000);

        // Randomized traffic: latency, redirects and decode back-pressure.
        do_reset();
        idle = 0; vcnt = 0;
        for (int i = 0; i < 2000; i++) begin
            logic        rv;
            logic [31:0] rpc;
            if (wait_cnt == 0) lat = $urandom_range(0, 3);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = BASE + 32'($urandom_range(0, 255)) * 32'd4;
            step(rv, rpc, ($urandom_range(0, 9) < 7));
            if (s_valid) begin
                idle = 0;
                vcnt++;
            end else begin
                idle++;
            end
            if (idle > 40) begin
                chk("rand_watchdog", idle, 0);
                break;
            end
        end
        chk("rand_progress", {31'h0, vcnt > 200}, 32'h1);
        chk("rand_no_fault", {31'h0, fault}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
